// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: access sizes, funct3 encodings, LSU FSM states
// and lane-alignment helpers.
package riscv_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } lsu_size_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] LDU_ILLEGAL = 3'b111;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;
  localparam logic [2:0] SD = 3'b011;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } lsu_state_e;

  function automatic logic [7:0] size_mask(lsu_size_e sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  // Forces the byte offset down to the natural alignment of the access size.
  function automatic logic [2:0] align_off(logic [2:0] a, lsu_size_e sz);
    case (sz)
      SZ_B:    return a;
      SZ_H:    return {a[2:1], 1'b0};
      SZ_W:    return {a[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, memory and response handshake bundle of the load/store unit.
// slave is the LSU's view; master is the surrounding pipeline/memory view.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned RD_W   = 5
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [63:0]       req_wdata;
  logic [RD_W-1:0]   req_rd;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wstrb;
  logic              mem_rvalid;
  logic [63:0]       mem_rdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic [RD_W-1:0]   resp_rd;
  logic              resp_err;

  modport slave (
    input  req_valid, req_addr, req_we, req_funct3, req_wdata, req_rd,
    input  mem_gnt, mem_rvalid, mem_rdata, resp_ready,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output resp_valid, resp_rdata, resp_rd, resp_err
  );

  modport master (
    output req_valid, req_addr, req_we, req_funct3, req_wdata, req_rd,
    output mem_gnt, mem_rvalid, mem_rdata, resp_ready,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  resp_valid, resp_rdata, resp_rd, resp_err
  );

endinterface

// File: rtl/lsu_load_align.sv
// Selects the load lane of a 64-bit read doubleword and sign- or zero-extends it.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] data_o
);

  lsu_size_e   sz;
  logic [63:0] lane;
  logic        sext;

  always_comb begin
    sz   = lsu_size_e'(funct3_i[1:0]);
    lane = rdata_i >> {align_off(addr_i, sz), 3'b000};
    sext = ~funct3_i[2];
    case (sz)
      SZ_B:    data_o = {{56{sext & lane[7]}}, lane[7:0]};
      SZ_H:    data_o = {{48{sext & lane[15]}}, lane[15:0]};
      SZ_W:    data_o = {{32{sext & lane[31]}}, lane[31:0]};
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one aligned doubleword transaction per request, extended load data out.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned RD_W   = 5
) (
  input logic                clk,
  input logic                rst_n,
  load_store_unit_if.slave   bus
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [2:0]  off_q;

  lsu_size_e   sz_in;
  logic [2:0]  off_in;
  logic        req_err;
  logic [63:0] load_data;

  always_comb begin
    sz_in   = lsu_size_e'(bus.req_funct3[1:0]);
    off_in  = align_off(bus.req_addr[2:0], sz_in);
    req_err = bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == LDU_ILLEGAL);
`ifdef LSU_MISALIGN_TRAP_EN
    if (off_in != bus.req_addr[2:0]) req_err = 1'b1;
`endif
  end

  assign bus.req_ready = (state_q == StIdle) & rst_n;

  lsu_load_align u_load_align (
    .rdata_i  (bus.mem_rdata),
    .addr_i   (off_q),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      we_q           <= 1'b0;
      funct3_q       <= '0;
      off_q          <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_wstrb  <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_rd    <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid && bus.req_ready) begin
            we_q           <= bus.req_we;
            funct3_q       <= bus.req_funct3;
            off_q          <= off_in;
            bus.resp_rd    <= bus.req_rd;
            bus.resp_rdata <= '0;
            bus.resp_err   <= req_err;
            if (req_err) begin
              // Errors skip memory entirely and respond on the next cycle.
              state_q        <= StResp;
              bus.resp_valid <= 1'b1;
            end else begin
              state_q       <= StReq;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_we;
              bus.mem_addr  <= {bus.req_addr[ADDR_W-1:3], 3'b000};
              bus.mem_wstrb <= bus.req_we ? (size_mask(sz_in) << off_in) : 8'h00;
              bus.mem_wdata <= bus.req_we ? (bus.req_wdata << {off_in, 3'b000}) : 64'h0;
            end
          end
        end
        StReq: begin
          if (bus.mem_gnt) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_wstrb <= 8'h00;
            if (we_q) begin
              state_q        <= StResp;
              bus.resp_valid <= 1'b1;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (bus.mem_rvalid) begin
            bus.resp_rdata <= load_data;
            bus.resp_valid <= 1'b1;
            state_q        <= StResp;
          end
        end
        StResp: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset-abort sequence and
// randomized accesses checked against a byte-arithmetic reference model.
`timescale 1ns/1ps
module tb_load_store_unit;
  import riscv_pkg::*;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned RD_W   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W), .RD_W(RD_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W), .RD_W(RD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [2:0]  funct3;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    int          gd;
    int          rvd;
    int          rdy;
    bit          spur;
  } txn_t;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    logic [63:0] maddr;
    logic [7:0]  wstrb;
    logic [63:0] mwdata;
    int          lat;
  } exp_t;

  typedef struct {
    txn_t t;
    exp_t e;
  } vec_t;

  typedef struct {
    int          req_cycles;
    logic [63:0] maddr;
    logic        mwe;
    logic [7:0]  wstrb;
    logic [63:0] mwdata;
    int          lat;
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        err;
    bit          unstable;
    bit          ready_hi;
    bit          timeout;
  } obs_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: byte arithmetic on size, offset and extension rules.
  function automatic exp_t model(input txn_t t);
    exp_t        e;
    int          nb;
    int          off;
    int          bits;
    logic [63:0] mask;
    logic [63:0] v;
    nb    = 1 << t.funct3[1:0];
    off   = (int'(t.addr[2:0]) / nb) * nb;
    e.err = t.we ? t.funct3[2] : (t.funct3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((int'(t.addr[2:0]) % nb) != 0) e.err = 1'b1;
`endif
    e.maddr  = t.addr & ~64'h7;
    e.wstrb  = t.we ? 8'(((1 << nb) - 1) << off) : 8'h00;
    e.mwdata = t.wdata << (8 * off);
    bits     = 8 * nb;
    mask     = (bits == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << bits) - 64'd1);
    v        = (t.rdata >> (8 * off)) & mask;
    if (!t.funct3[2] && v[bits-1]) v = v | ~mask;
    e.rdata  = (e.err || t.we) ? 64'h0 : v;
    e.lat    = e.err ? 1 : (t.we ? t.gd + 2 : t.gd + t.rvd + 3);
    return e;
  endfunction

  function automatic vec_t mkv(input logic [63:0] addr, input logic we, input logic [2:0] f3,
                               input logic [63:0] wdata, input logic [63:0] rdata, input int gd,
                               input int rvd, input int rdy, input logic err,
                               input logic [63:0] erdata, input logic [63:0] emaddr,
                               input logic [7:0] ewstrb, input logic [63:0] emwdata,
                               input int lat);
    vec_t v;
    v.t = '{addr: addr, we: we, funct3: f3, wdata: wdata, rd: 5'(addr[6:2]), rdata: rdata,
            gd: gd, rvd: rvd, rdy: rdy, spur: 1'b0};
    v.e = '{err: err, rdata: erdata, maddr: emaddr, wstrb: ewstrb, mwdata: emwdata, lat: lat};
    return v;
  endfunction

  task automatic clear_inputs();
    bus.req_valid  = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.resp_ready = 1'b0;
  endtask

  // Drives one request and plays memory/writeback with the requested delays.
  task automatic run_txn(input txn_t t, output obs_t o);
    int k, req_cnt, rsp_cnt, gnt_k;
    bit granted, rv_done, ready_drv, done;
    o.req_cycles = 0; o.maddr = '0; o.mwe = 1'b0; o.wstrb = '0; o.mwdata = '0; o.lat = -1;
    o.rdata = '0; o.rd = '0; o.err = 1'b0; o.unstable = 0; o.ready_hi = 0; o.timeout = 0;
    req_cnt = 0; rsp_cnt = 0; gnt_k = 0; granted = 0; rv_done = 0; ready_drv = 0; done = 0;
    @(negedge clk);
    check("idle_req_ready", bus.req_ready, 1'b1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = t.addr;
    bus.req_we     = t.we;
    bus.req_funct3 = t.funct3;
    bus.req_wdata  = t.wdata;
    bus.req_rd     = t.rd;
    for (k = 1; k <= 80 && !done; k++) begin
      @(negedge clk);
      clear_inputs();
      bus.mem_rdata = ~t.rdata;
      if (bus.resp_valid == 1'b0 && ready_drv) done = 1;
      else if (bus.req_ready) o.ready_hi = 1;
      if (bus.mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          o.maddr = bus.mem_addr; o.mwe = bus.mem_we; o.wstrb = bus.mem_wstrb;
          o.mwdata = bus.mem_wdata;
        end else if (o.maddr !== bus.mem_addr || o.mwe !== bus.mem_we ||
                     o.wstrb !== bus.mem_wstrb || o.mwdata !== bus.mem_wdata) begin
          o.unstable = 1;
        end
        if (!granted && req_cnt > t.gd) begin
          bus.mem_gnt = 1'b1; granted = 1; gnt_k = k;
        end
        if (t.spur) bus.mem_rvalid = 1'b1;
      end
      if (granted && !rv_done && !t.we && k >= gnt_k + 1 + t.rvd) begin
        bus.mem_rvalid = 1'b1; bus.mem_rdata = t.rdata; rv_done = 1;
      end
      if (bus.resp_valid) begin
        rsp_cnt++;
        if (rsp_cnt == 1) begin
          o.lat = k; o.rdata = bus.resp_rdata; o.rd = bus.resp_rd; o.err = bus.resp_err;
        end else if (o.rdata !== bus.resp_rdata || o.rd !== bus.resp_rd ||
                     o.err !== bus.resp_err) begin
          o.unstable = 1;
        end
        if (t.spur) bus.mem_rvalid = 1'b1;
        if (rsp_cnt > t.rdy) begin
          bus.resp_ready = 1'b1; ready_drv = 1;
        end
      end
    end
    o.req_cycles = req_cnt;
    if (!done) o.timeout = 1;
    clear_inputs();
  endtask

  task automatic compare(input string tag, input txn_t t, input exp_t e, input obs_t o);
    check({tag, "_timeout"}, o.timeout, 1'b0);
    check({tag, "_err"}, o.err, e.err);
    check({tag, "_rdata"}, o.rdata, e.rdata);
    check({tag, "_rd"}, o.rd, t.rd);
    check({tag, "_latency"}, o.lat, e.lat);
    check({tag, "_stable"}, o.unstable, 1'b0);
    check({tag, "_req_ready_low"}, o.ready_hi, 1'b0);
    if (e.err) begin
      check({tag, "_no_mem_req"}, o.req_cycles, 0);
    end else begin
      check({tag, "_req_cycles"}, o.req_cycles, t.gd + 1);
      check({tag, "_mem_addr"}, o.maddr, e.maddr);
      check({tag, "_mem_we"}, o.mwe, t.we);
      check({tag, "_mem_wstrb"}, o.wstrb, e.wstrb);
      if (t.we) check({tag, "_mem_wdata"}, o.mwdata, e.mwdata);
    end
  endtask

  initial begin
    vec_t vt[$];
    txn_t t;
    obs_t o;
    exp_t e;

    clear_inputs();
    bus.req_addr = '0; bus.req_we = 1'b0; bus.req_funct3 = '0; bus.req_wdata = '0;
    bus.req_rd = '0; bus.mem_rdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 64'h0);
    check("rst_mem_wdata", bus.mem_wdata, 64'h0);
    check("rst_mem_wstrb", bus.mem_wstrb, 8'h0);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_rdata", bus.resp_rdata, 64'h0);
    check("rst_resp_rd", bus.resp_rd, 5'h0);
    check("rst_resp_err", bus.resp_err, 1'b0);
    rst_n = 1'b1;

    // Directed vectors: addr, we, f3, wdata, rdata, gd, rvd, rdy | err, rdata, maddr, strb, wdata, lat
    vt.push_back(mkv(64'h1000, 0, LD, 0, 64'h8877665544332211, 0, 0, 0,
                     0, 64'h8877665544332211, 64'h1000, 8'h00, 0, 3));
    vt.push_back(mkv(64'h1007, 0, LB, 0, 64'h8877665544332211, 0, 0, 0,
                     0, 64'hffffffffffffff88, 64'h1000, 8'h00, 0, 3));
    vt.push_back(mkv(64'h1007, 0, LBU, 0, 64'h8877665544332211, 0, 0, 0,
                     0, 64'h88, 64'h1000, 8'h00, 0, 3));
    vt.push_back(mkv(64'h2002, 1, SH, 64'habcd, 0, 0, 0, 0,
                     0, 0, 64'h2000, 8'h0c, 64'habcd0000, 2));
    vt.push_back(mkv(64'h2004, 1, SW, 64'h12345678, 0, 4, 0, 3,
                     0, 0, 64'h2000, 8'hf0, 64'h1234567800000000, 6));
`ifdef LSU_MISALIGN_TRAP_EN
    vt.push_back(mkv(64'h3002, 0, LW, 0, 64'h112233448899aabb, 0, 0, 0,
                     1, 0, 0, 0, 0, 1));
    vt.push_back(mkv(64'h2003, 1, SH, 64'habcd, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 1));
`else
    vt.push_back(mkv(64'h3002, 0, LW, 0, 64'h112233448899aabb, 0, 0, 0,
                     0, 64'hffffffff8899aabb, 64'h3000, 8'h00, 0, 3));
    vt.push_back(mkv(64'h2003, 1, SH, 64'habcd, 0, 0, 0, 0,
                     0, 0, 64'h2000, 8'h0c, 64'habcd0000, 2));
`endif
    vt.push_back(mkv(64'h3000, 0, 3'b111, 0, 64'h1234, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    vt.push_back(mkv(64'h3000, 1, 3'b100, 64'h55, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    vt.push_back(mkv(64'h4006, 0, LHU, 0, 64'hbeef000000000000, 0, 0, 0,
                     0, 64'hbeef, 64'h4000, 8'h00, 0, 3));
    vt.push_back(mkv(64'h4006, 0, LH, 0, 64'hbeef000000000000, 0, 0, 0,
                     0, 64'hffffffffffffbeef, 64'h4000, 8'h00, 0, 3));
    vt.push_back(mkv(64'h5000, 1, SD, 64'h0102030405060708, 0, 1, 0, 0,
                     0, 0, 64'h5000, 8'hff, 64'h0102030405060708, 3));
    vt.push_back(mkv(64'h6004, 0, LWU, 0, 64'h89abcdef00000000, 0, 2, 0,
                     0, 64'h89abcdef, 64'h6000, 8'h00, 0, 5));
    for (int i = 0; i < vt.size(); i++) begin
      run_txn(vt[i].t, o);
      compare($sformatf("vec%0d", i), vt[i].t, vt[i].e, o);
    end

    // Reset while waiting for read data abandons the load
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 64'h7000; bus.req_we = 1'b0;
    bus.req_funct3 = LD; bus.req_rd = 5'd9;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_mem_req", bus.mem_req, 1'b1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("abort_wait_no_resp", bus.resp_valid, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_mem_req_low", bus.mem_req, 1'b0);
    check("abort_resp_valid", bus.resp_valid, 1'b0);
    check("abort_req_ready", bus.req_ready, 1'b0);
    check("abort_mem_addr", bus.mem_addr, 64'h0);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hdeadbeefdeadbeef;
    repeat (3) begin
      @(negedge clk);
      check("abort_late_rvalid_ignored", bus.resp_valid, 1'b0);
    end
    bus.mem_rvalid = 1'b0;
    t = '{addr: 64'h7008, we: 1'b0, funct3: LD, wdata: 64'h0, rd: 5'd10,
          rdata: 64'h0badc0de12345678, gd: 0, rvd: 0, rdy: 0, spur: 1'b0};
    run_txn(t, o);
    compare("after_reset_ld", t, model(t), o);

    // Randomized accesses against the reference model
    for (int i = 0; i < 150; i++) begin
      t.addr   = {$urandom, $urandom};
      t.we     = 1'($urandom_range(0, 1));
      t.funct3 = 3'($urandom_range(0, 7));
      t.wdata  = {$urandom, $urandom};
      t.rd     = 5'($urandom_range(0, 31));
      t.rdata  = {$urandom, $urandom};
      t.gd     = $urandom_range(0, 3);
      t.rvd    = $urandom_range(0, 3);
      t.rdy    = $urandom_range(0, 3);
      t.spur   = 1'($urandom_range(0, 1));
      e = model(t);
      run_txn(t, o);
      compare($sformatf("rnd%0d", i), t, e, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU.
- Consumes the ALU result as the effective address, together with store data and the access type.
- Issues one aligned 64-bit doubleword transaction to data memory.
- Returns load data, sign- or zero-extended, to writeback.
- Multi-cycle. Uses valid/ready handshakes on the upstream side, the memory side and the writeback side.

Parameters:
- ADDR_W, 64: effective address width; also the width of mem_addr.
- RD_W, 5: destination register index width.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  an access request is presented.
- req_ready  output  1  the unit can accept a request.
- req_addr  input  ADDR_W  effective address (ALU result).
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3: [1:0] size (B/H/W/D), [2] unsigned load.
- req_wdata  input  64  store data, LSB-justified.
- req_rd  input  RD_W  load destination register.
- mem_req  output  1  memory request.
- mem_gnt  input  1  memory accepted the request.
- mem_we  output  1  write enable.
- mem_addr  output  ADDR_W  doubleword-aligned address.
- mem_wdata  output  64  lane-shifted store data.
- mem_wstrb  output  8  byte strobes.
- mem_rvalid  input  1  read data is valid.
- mem_rdata  input  64  read doubleword.
- resp_valid  output  1  response is valid.
- resp_ready  input  1  writeback consumed the response.
- resp_rdata  output  64  extended load data; 0 for stores and errors.
- resp_rd  output  RD_W  echo of req_rd.
- resp_err  output  1  illegal funct3 or misaligned access (see Optional Feature).

Behaviour:
- Reset:
  - state = IDLE.
  - req_ready, mem_req, mem_we, resp_valid, resp_err = 0.
  - mem_addr, mem_wdata, mem_wstrb, resp_rdata, resp_rd = 0.
  - req_ready = (state==IDLE) & rst_n, so it is 0 while rst_n is low.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On req_valid & req_ready, register addr, we, funct3, wdata and rd.
  - If the request is an error (funct3==3'b111 for a load; funct3[2]==1 for a store; misaligned with the feature enabled), go to RESP with resp_err=1. No memory transaction is issued.
  - Otherwise go to REQ.
- REQ:
  - Drive mem_req=1, held stable until mem_gnt.
  - mem_addr = {addr[ADDR_W-1:3], 3'b000}.
  - Stores:
    - mem_wstrb = mask << addr[2:0], where mask is 01/03/0F/FF for B/H/W/D.
    - mem_wdata = wdata << (8*addr[2:0]).
  - Loads: mem_wstrb = 0.
  - On mem_gnt: a store goes to RESP; a load goes to WAIT. mem_req deasserts on the next cycle.
- WAIT:
  - On mem_rvalid, select the byte lane at addr[2:0] and sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) to 64 bits.
  - Register the result into resp_rdata, then go to RESP.
  - mem_rvalid in any state other than WAIT is ignored. The earliest accepted rvalid is the cycle after gnt.
- RESP:
  - resp_valid=1; resp_rdata, resp_rd and resp_err are held stable.
  - On resp_ready, go to IDLE with resp_valid=0 on the next cycle.
  - The next request can be accepted one cycle after the handshake, i.e. there is no accept in the RESP cycle.
- Latency with gnt in the first REQ cycle and immediate resp_ready:
  - Store: resp_valid 2 cycles after accept.
  - Load with rvalid 1 cycle after gnt: resp_valid 3 cycles after accept.
- Misalignment without the feature: an access with low bits set beyond its size is silently aligned down, e.g. a halfword at ...1 is treated as ...0. The same forced alignment applies to the strobe shift and the lane select.
- Reset mid-operation: the transaction is abandoned, all outputs return to reset values at the reset edge, and no response is produced. The memory side is expected to be reset in the same cycle.
- Back-pressure: resp_ready=0 holds RESP indefinitely, and req_ready stays 0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: any access with addr[0]!=0 (H), addr[1:0]!=0 (W) or addr[2:0]!=0 (D) completes as IDLE→RESP with resp_err=1, resp_rdata=0 and no mem_req.
- Undefined: low address bits are forced to natural alignment, and resp_err is raised only for illegal funct3.

Decomposition:
- Shared package riscv_pkg:
  - Size enum: SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, SZ_D=2'b11.
  - funct3 constants LB/LH/LW/LD/LBU/LHU/LWU and SB/SH/SW/SD.
  - LSU state enum.
- One natural sub-module: lsu_load_align. It is combinational: mem_rdata, addr[2:0] and funct3 in; extended 64-bit data out. It can be tested standalone.

Test Plan:
- LD from 0x1000, mem_rdata=0x8877665544332211, gnt same cycle, rvalid +1 → resp_rdata=0x8877665544332211 exactly 3 cycles after accept, mem_addr=0x1000, mem_wstrb=0x00.
- LB from 0x1007 with rdata byte7=0x88 → resp_rdata=0xFFFFFFFFFFFFFF88. LBU from the same address → 0x0000000000000088.
- SH to 0x2002, wdata=0xABCD → mem_addr=0x2000, mem_wstrb=0x0C, mem_wdata[31:16]=0xABCD; resp_valid 2 cycles after accept, resp_err=0.
- mem_gnt held low for 4 cycles, then resp_ready low for 3 cycles → mem_req and all mem_* outputs stable throughout; req_ready=0 until the resp handshake; exactly one response.
- LW at 0x3002: with LSU_MISALIGN_TRAP_EN → resp_err=1, mem_req never asserted. Without it → reads lane 0x3000 word, resp_err=0. funct3=3'b111 → resp_err=1 in both builds.
- rst_n low during WAIT → next cycle state IDLE, mem_req=0, resp_valid=0. A later rvalid is ignored, and a new LD after reset completes normally.
